// File: rtl/audio_pkg.sv
// audio_pkg -- shared audio definitions for the mixer/PWM codebase.
//   SAMPLE_W           : width of one audio sample (8 bits, unsigned)
//   SAMPLE_DIV_DEFAULT : default clk cycles per audio sample period
//   SAMPLE_MAX         : largest representable sample, used as the saturation ceiling
//   sample_t           : one unsigned audio sample
package audio_pkg;

  localparam int SAMPLE_W           = 8;
  localparam int SAMPLE_DIV_DEFAULT = 2500;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = '1;

endpackage

// File: rtl/pwm_dac.sv
// pwm_dac -- 8-bit free-running PWM DAC.
// A free 8-bit counter sweeps 0..255. The duty register is reloaded from
// duty_in only as the counter wraps 255->0, so a new sample never distorts a
// period that is already in progress.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   duty_in : requested duty (high cycles per 256), sampled at period wrap
//   pwm_out : registered PWM output, (pwm_cnt < duty) of the previous cycle
module pwm_dac
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t duty_in,
  output logic    pwm_out
);

  sample_t pwm_cnt;
  sample_t duty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;  // natural 8-bit wrap 255 -> 0
      if (pwm_cnt == SAMPLE_MAX) begin
        duty <= duty_in;
      end
      // duty 0 never asserts; duty 255 asserts for 255 of every 256 cycles.
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/audio_mixer_pwm.sv
// audio_mixer_pwm -- multi-voice sample mixer feeding a PWM audio DAC.
// Once per sample period the enabled voices are captured (stage 1), summed at
// full precision (stage 2), then optionally attenuated and saturated to 8 bits
// into mix_out (stage 3). mix_out drives the pwm_dac duty input.
//
// Optional feature: define MIXER_VOLUME_EN to add the 3-bit 'vol' input, a
// right-shift attenuation applied to the sum before saturation. vol is
// captured together with the voices. Without the macro no shift is applied.
//
// Parameters:
//   NUM_VOICES : number of 8-bit voices mixed (1..8)
//   SAMPLE_DIV : clk cycles per audio sample period (>= 4)
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   voice_in    : packed unsigned samples, voice i at [8i+7:8i]
//   voice_en    : per-voice mix enable, 1 = included
//   vol         : (MIXER_VOLUME_EN only) attenuation shift amount
//   sample_tick : one-cycle strobe per sample period
//   mix_out     : registered mixed sample, held between mix_valid pulses
//   mix_valid   : one-cycle pulse when mix_out updates (3 cycles after sample_tick)
//   pwm_out     : 1-bit PWM audio output
module audio_mixer_pwm
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES-1:0]          voice_en,
`ifdef MIXER_VOLUME_EN
  input  logic [2:0]                     vol,
`endif
  output logic                           sample_tick,
  output sample_t                        mix_out,
  output logic                           mix_valid,
  output logic                           pwm_out
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(SAMPLE_DIV - 2);

  // ---------------------------------------------------------------------------
  // Sample-rate divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;

  // sample_tick is registered but decoded one count early, so it is high in
  // exactly the cycle where div_cnt == SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      sample_tick <= (div_cnt == DIV_PRE);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture gated voices (and volume) on sample_tick
  // ---------------------------------------------------------------------------
  sample_t    voice_s1 [NUM_VOICES];
  logic       valid_s1;
  logic [2:0] vol_s2;

`ifdef MIXER_VOLUME_EN
  logic [2:0] vol_s1;
`endif

  // NOTE: the per-voice capture array is a small pipeline register bank, not a
  // RAM, so it is cleared on reset like every other pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_s1[i] <= '0;
      end
`ifdef MIXER_VOLUME_EN
      vol_s1 <= '0;
`endif
    end else begin
      valid_s1 <= sample_tick;
      if (sample_tick) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          voice_s1[i] <= voice_in[i*SAMPLE_W +: SAMPLE_W] & {SAMPLE_W{voice_en[i]}};
        end
`ifdef MIXER_VOLUME_EN
        vol_s1 <= vol;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: full-precision sum (cannot overflow SUM_W)
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] sum_s2;
  logic             valid_s2;

  // NOTE: combinational accumulation uses blocking assignments, and sum_next is
  // defaulted first so no path through the block can infer a latch.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum_next = sum_next + SUM_W'(voice_s1[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_s2   <= '0;
      valid_s2 <= 1'b0;
`ifdef MIXER_VOLUME_EN
      vol_s2   <= '0;
`endif
    end else begin
      valid_s2 <= valid_s1;
      if (valid_s1) begin
        sum_s2 <= sum_next;
`ifdef MIXER_VOLUME_EN
        vol_s2 <= vol_s1;
`endif
      end
    end
  end

`ifndef MIXER_VOLUME_EN
  assign vol_s2 = 3'd0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: attenuate, saturate to 8 bits, publish
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] sum_shifted;
  sample_t          mix_next;

  always_comb begin
    sum_shifted = sum_s2 >> vol_s2;
    mix_next    = (sum_shifted > SUM_W'(SAMPLE_MAX)) ? SAMPLE_MAX
                                                     : sum_shifted[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= valid_s2;
      if (valid_s2) begin
        mix_out <= mix_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM DAC
  // ---------------------------------------------------------------------------
  pwm_dac u_pwm_dac (
    .clk     (clk),
    .rst     (rst),
    .duty_in (mix_out),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// tb_audio_mixer_pwm -- directed self-checking bench for audio_mixer_pwm.
// Runs with SAMPLE_DIV=10 and four voices. Cycle n counts rising edges since
// the last edge with rst high, so divider and PWM counter both equal n there.
module tb_audio_mixer_pwm;

  localparam int NV  = 4;
  localparam int DIV = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NV*8-1:0] voice_in = '0;
  logic [NV-1:0] voice_en = '0;
  logic          sample_tick;
  logic [7:0]    mix_out;
  logic          mix_valid;
  logic          pwm_out;
`ifdef MIXER_VOLUME_EN
  logic [2:0]    vol = '0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  audio_mixer_pwm #(
    .NUM_VOICES (NV),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .voice_in    (voice_in),
    .voice_en    (voice_en),
`ifdef MIXER_VOLUME_EN
    .vol         (vol),
`endif
    .sample_tick (sample_tick),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .pwm_out     (pwm_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * DIV; n++) begin
      if (sample_tick) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (mix_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Apply inputs, let one tick capture them, scramble inputs afterwards, then
  // compare the published sample and that it holds for the following cycle.
  task automatic run_sample(input logic [31:0] vin, input logic [3:0] en,
                            input logic [7:0] exp_mix, input string name);
    bit ok;
    voice_in = vin;
    voice_en = en;
    wait_tick(ok);
    if (ok) begin
      step();
      voice_in = ~vin;
      voice_en = ~en;
      wait_valid(ok);
    end
    total_cnt++;
    if (!ok) $display("FAIL %s: timeout, got no mix_valid expected pulse", name);
    else if (mix_out !== exp_mix)
      $display("FAIL %s: mix_out got %0d expected %0d", name, mix_out, exp_mix);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mix_valid !== 1'b0 || mix_out !== exp_mix)
      $display("FAIL %s_hold: valid/mix got %b/%0d expected 0/%0d",
               name, mix_valid, mix_out, exp_mix);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total_cnt++;
    if (sample_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", sample_tick);
    else pass_cnt++;
    total_cnt++;
    if (mix_out !== 8'd0) $display("FAIL reset_mix: got %0d expected 0", mix_out);
    else pass_cnt++;
    total_cnt++;
    if (mix_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", mix_valid);
    else pass_cnt++;
    total_cnt++;
    if (pwm_out !== 1'b0) $display("FAIL reset_pwm: got %b expected 0", pwm_out);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // Ticks at cycles 9,19,29; valid pulses at 12,22,32.
  task automatic test_sample_timing();
    logic exp_tick, exp_valid;
    do_reset();
    voice_in = 32'h0102_0304;
    voice_en = 4'hF;
    for (int n = 0; n < 35; n++) begin
      exp_tick  = (n % DIV == 9);
      exp_valid = (n >= 12) && (n % DIV == 2);
      total_cnt++;
      if (sample_tick !== exp_tick)
        $display("FAIL tick_cycle_%0d: got %b expected %b", n, sample_tick, exp_tick);
      else pass_cnt++;
      total_cnt++;
      if (mix_valid !== exp_valid)
        $display("FAIL valid_cycle_%0d: got %b expected %b", n, mix_valid, exp_valid);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_mix();
    run_sample(32'h463C_3228, 4'b0101, 8'd100, "mix_en0101");
    run_sample(32'h463C_3228, 4'b1111, 8'd220, "mix_en1111");
    run_sample(32'h463C_3228, 4'b1000, 8'd70,  "mix_voice3");
    run_sample(32'h463C_3228, 4'b0000, 8'd0,   "mix_none");
    run_sample(32'h0000_64C8, 4'b1111, 8'd255, "mix_sat300");
    run_sample(32'hFFFF_FFFF, 4'b1111, 8'd255, "mix_sat1020");
    run_sample(32'h0000_00C8, 4'b0001, 8'd200, "mix_single");
  endtask

`ifdef MIXER_VOLUME_EN
  task automatic test_volume();
    vol = 3'd2;
    run_sample(32'h0000_64C8, 4'b1111, 8'd75,  "vol2");
    vol = 3'd7;
    run_sample(32'h0000_64C8, 4'b1111, 8'd2,   "vol7");
    vol = 3'd1;
    run_sample(32'hFFFF_FFFF, 4'b1111, 8'd255, "vol1_sat");
    vol = 3'd0;
  endtask
`endif

  // Reset lands one cycle after the tick; the in-flight sample must vanish.
  task automatic test_reset_midpipe();
    bit ok;
    do_reset();
    voice_in = 32'h0000_00C8;
    voice_en = 4'b0001;
    wait_tick(ok);
    total_cnt++;
    if (!ok) $display("FAIL midpipe_tick: timeout, got no tick expected tick");
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 11; n++) begin
      total_cnt++;
      if (mix_valid !== 1'b0 || mix_out !== 8'd0)
        $display("FAIL midpipe_cycle_%0d: valid/mix got %b/%0d expected 0/0",
                 n, mix_valid, mix_out);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic count_window(input int change_at, input logic [31:0] new_vin,
                              input logic [3:0] new_en, output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == change_at) begin
        voice_in = new_vin;
        voice_en = new_en;
      end
      if (pwm_out === 1'b1) highs++;
      step();
    end
  endtask

  // Window k covers PWM counts 1..255,0 of one period. Each mid-window input
  // change must only take effect from the following period.
  task automatic test_pwm();
    bit ok;
    int highs;
    int budget;
    do_reset();
    voice_in = 32'h0000_0040;
    voice_en = 4'b0001;
    wait_tick(ok);
    if (ok) begin
      step();
      wait_valid(ok);
    end
    total_cnt++;
    if (!ok || mix_out !== 8'd64)
      $display("FAIL pwm_setup: mix_out got %0d expected 64", mix_out);
    else pass_cnt++;
    step();
    budget = 0;
    while (cyc % 256 != 0 && budget < 300) begin
      step();
      budget++;
    end
    total_cnt++;
    if (cyc % 256 != 0) $display("FAIL pwm_align: timeout, got cyc %0d expected wrap", cyc);
    else pass_cnt++;
    step();
    count_window(8, 32'h0000_0040, 4'b0000, highs);
    total_cnt++;
    if (highs != 64) $display("FAIL pwm_duty64: high cycles got %0d expected 64", highs);
    else pass_cnt++;
    count_window(8, 32'h0000_00FF, 4'b0001, highs);
    total_cnt++;
    if (highs != 0) $display("FAIL pwm_duty0: high cycles got %0d expected 0", highs);
    else pass_cnt++;
    count_window(300, 32'h0, 4'b0, highs);
    total_cnt++;
    if (highs != 255) $display("FAIL pwm_duty255: high cycles got %0d expected 255", highs);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sample_timing();
    test_mix();
`ifdef MIXER_VOLUME_EN
    test_volume();
`endif
    test_reset_midpipe();
    test_pwm();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/audio_mixer_pwm.md
AUDIO_MIXER_PWM -- requirements
Module: audio_mixer_pwm

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, meaning number of 8-bit sample voices mixed (1..8).
REQ-002 SHALL have parameter SAMPLE_DIV, default 2500, meaning clk cycles per audio sample period (>=4).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port voice_in  input  NUM_VOICES*8  unsigned 8-bit samples, voice i at bits [8i+7:8i], from the sample players.
REQ-006 SHALL have port voice_en  input  NUM_VOICES  per-voice mix enable, 1 = included.
REQ-007 SHALL have port sample_tick  output  1  one-cycle strobe per sample period.
REQ-008 SHALL have port mix_out  output  8  registered mixed sample.
REQ-009 SHALL have port mix_valid  output  1  one-cycle pulse when mix_out updates.
REQ-010 SHALL have port pwm_out  output  1  1-bit PWM audio output.

Function
REQ-011 SHALL count div_cnt 0..SAMPLE_DIV-1, wrapping to 0, and assert sample_tick in exactly the cycle div_cnt == SAMPLE_DIV-1.
REQ-012 SHALL, in the cycle after sample_tick (stage 1), register each voice as voice_in slice ANDed with voice_en bit; unselected voices contribute 0.
REQ-013 SHALL, in stage 2, register the unsigned sum of stage-1 voices at width 8+clog2(NUM_VOICES) with no overflow.
REQ-014 SHALL, in stage 3, load mix_out with the sum saturated to 255 and pulse mix_valid; latency sample_tick to mix_valid = 3 cycles.
REQ-015 SHALL hold mix_out unchanged between mix_valid pulses.
REQ-016 SHALL run a free 8-bit pwm_cnt 0..255, wrapping to 0.
REQ-017 SHALL load the duty register from mix_out only in the cycle pwm_cnt wraps 255->0; a mix_out change mid-period SHALL NOT affect the current period.
REQ-018 SHALL drive pwm_out registered, equal to (pwm_cnt < duty); duty 0 -> constant low, duty 255 -> high 255 of every 256 cycles.
REQ-019 SHALL accept voice_en/voice_in changes at any cycle; only values present in the stage-1 capture cycle are mixed.

Reset
REQ-020 SHALL, while rst is high at a rising edge, clear div_cnt, pwm_cnt, duty, all pipeline registers, sample_tick, mix_out, mix_valid, pwm_out to 0.
REQ-021 SHALL discard any in-flight sample on reset mid-pipeline; no mix_valid for it.
REQ-022 SHALL produce the first sample_tick SAMPLE_DIV cycles after rst deasserts.

Configuration
REQ-023 SHALL, with MIXER_VOLUME_EN defined, add port vol input 3 (attenuation) and right-shift the stage-2 sum by vol before saturation, vol sampled in the stage-1 cycle.
REQ-024 SHALL, with MIXER_VOLUME_EN undefined, omit port vol and apply zero shift.

Structure
REQ-025 SHALL take SAMPLE_W (8), the SAMPLE_DIV default and typedef sample_t (8-bit unsigned) from shared package audio_pkg.
REQ-026 SHALL place pwm_cnt, duty register and pwm_out generation in sub-module pwm_dac, instantiated once.

Verification
REQ-027 SHALL verify SAMPLE_DIV=10, rst released -> sample_tick at cycles 9, 19, 29 after release; mix_valid at 12, 22, 32.
REQ-028 SHALL verify voices 40,50,60,70, voice_en=4'b0101 -> mix_out=100; voice_en=4'b1111 -> mix_out=220.
REQ-029 SHALL verify voices 200,100,0,0 all enabled -> mix_out=255 (saturated, no wrap to 44).
REQ-030 SHALL verify mix_out=64 -> pwm_out high for exactly 64 of 256 cycles from next wrap; mix_out 0 -> pwm_out low for all 256 cycles.
REQ-031 SHALL verify rst asserted one cycle after sample_tick -> mix_valid never pulses for that sample, mix_out stays 0.
REQ-032 SHALL verify with MIXER_VOLUME_EN: voices 200,100,0,0, vol=2 -> mix_out=75.
